// File: rtl/ps2_event_sequencer.sv
// ps2_event_sequencer
//   Drains the ps2_keyboard scan-code FIFO one byte every three cycles,
//   decodes E0/F0 prefixes, suppresses typematic repeats, tracks the held
//   key and a make counter, and queues complete key events for a consumer.
//
// Ports
//   clk          in   1   system clock
//   clrn         in   1   asynchronous active-low reset
//   ready        in   1   keyboard FIFO non-empty, data valid while high
//   data         in   8   scan byte at keyboard FIFO head
//   nextdata_n   out  1   active-low pop strobe to keyboard FIFO (registered)
//   ev_valid     out  1   event queue non-empty
//   ev_ready     in   1   consumer takes ev_data when ev_valid & ev_ready
//   ev_data      out  10  {brk, ext, code[7:0]} at queue head
//   key_held     out  1   a key is currently held
//   held_code    out  8   code of held key, 0 when none
//   held_ext     out  1   held key carried the E0 prefix
//   key_count    out  8   accepted make events, wraps
//   ev_overflow  out  1   sticky: an event was dropped on a full queue
module ps2_event_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [9:0] ev_data,
    output logic       key_held,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic [7:0] key_count,
    output logic       ev_overflow
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_GAP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_nextdata_n_nxt;
    logic           w_latch;
    logic           w_proc;

    logic           r_nextdata_n;
    logic [7:0]     r_byte;
    logic           r_ext_p;
    logic           r_brk_p;
    logic [TW-1:0]  r_tmo;

    logic           r_key_held;
    logic [7:0]     r_held_code;
    logic           r_held_ext;
    logic [7:0]     r_key_count;
    logic           r_ev_overflow;

    logic [9:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_cnt;

    logic           w_is_e0;
    logic           w_is_f0;
    logic           w_discard;
    logic           w_cand;
    logic           w_match;
    logic           w_repeat;
    logic           w_push;
    logic           w_make;
    logic           w_break;
    logic [9:0]     w_ev;
    logic           w_full;
    logic           w_pop;
    logic           w_wr;
    logic           w_drop;
    logic           w_tmo_hit;

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ready) w_state_nxt = S_POP;
            S_POP:   w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_latch          = (r_state == S_IDLE) && ready;
        w_nextdata_n_nxt = !w_latch;
        w_proc           = (r_state == S_POP);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_nextdata_n <= 1'b1;
            r_byte       <= '0;
        end else begin
            r_nextdata_n <= w_nextdata_n_nxt;
            if (w_latch) r_byte <= data;
        end
    end

    // ---------------- byte decode ----------------
    always_comb begin
        w_is_e0   = (r_byte == 8'hE0);
        w_is_f0   = (r_byte == 8'hF0);
        w_discard = !r_ext_p && !r_brk_p &&
                    ((r_byte == 8'hAA) || (r_byte == 8'hFA) || (r_byte == 8'hFE));
        w_cand    = w_proc && !w_is_e0 && !w_is_f0 && !w_discard;
        w_ev      = {r_brk_p, r_ext_p, r_byte};
        w_match   = r_key_held && ({r_held_ext, r_held_code} == {r_ext_p, r_byte});
        w_repeat  = !r_brk_p && w_match;
        w_push    = w_cand && !w_repeat;
        w_make    = w_push && !r_brk_p;
        w_break   = w_push && r_brk_p;
        w_tmo_hit = (TIMEOUT_CYC != 0) && (r_ext_p || r_brk_p) &&
                    (r_tmo == TW'(TMO_LAST));
    end

    // Processing a byte takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ext_p <= 1'b0;
            r_brk_p <= 1'b0;
            r_tmo   <= '0;
        end else if (w_proc) begin
            r_tmo <= '0;
            if (w_is_e0)      r_ext_p <= 1'b1;
            else if (w_is_f0) r_brk_p <= 1'b1;
            else if (w_cand) begin
                r_ext_p <= 1'b0;
                r_brk_p <= 1'b0;
            end
        end else if (w_tmo_hit) begin
            r_ext_p <= 1'b0;
            r_brk_p <= 1'b0;
            r_tmo   <= '0;
        end else if (r_ext_p || r_brk_p) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Held state and counter update even when the queue drops the event.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_key_held  <= 1'b0;
            r_held_code <= '0;
            r_held_ext  <= 1'b0;
            r_key_count <= '0;
        end else if (w_make) begin
            r_key_held  <= 1'b1;
            r_held_code <= r_byte;
            r_held_ext  <= r_ext_p;
            r_key_count <= r_key_count + 8'd1;
        end else if (w_break && w_match) begin
            r_key_held  <= 1'b0;
            r_held_code <= '0;
            r_held_ext  <= 1'b0;
        end
    end

    // ---------------- event queue ----------------
    always_comb begin
        w_full = (r_cnt == (AW+1)'(DEPTH));
        w_pop  = ev_valid && ev_ready;
        w_wr   = w_push && (!w_full || w_pop);
        w_drop = w_push && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= w_ev;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr          <= '0;
            r_rd          <= '0;
            r_cnt         <= '0;
            r_ev_overflow <= 1'b0;
        end else begin
            if (w_wr)   r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_wr && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
            else if (!w_wr && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
            if (w_drop) r_ev_overflow <= 1'b1;
        end
    end

    // Head entry is masked while empty so the output reads 0 after reset.
    always_comb begin
        ev_valid = (r_cnt != '0);
        ev_data  = ev_valid ? r_mem[r_rd] : '0;
    end

    always_comb begin
        nextdata_n  = r_nextdata_n;
        key_held    = r_key_held;
        held_code   = r_held_code;
        held_ext    = r_held_ext;
        key_count   = r_key_count;
        ev_overflow = r_ev_overflow;
    end

endmodule

// File: tb/tb_ps2_event_sequencer.sv
// Bench for ps2_event_sequencer: keyboard FIFO model, event consumer and a
// reference model of the decode rules kept as plain variables and queues.
module tb_ps2_event_sequencer;

    localparam int unsigned DEP = 8;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ev_ready = 1'b0;
    logic       nextdata_n;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       key_held;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] key_count;
    logic       ev_overflow;

    always #5 clk = ~clk;

    ps2_event_sequencer #(.DEPTH(DEP), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data),
        .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_data(ev_data), .key_held(key_held), .held_code(held_code),
        .held_ext(held_ext), .key_count(key_count), .ev_overflow(ev_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_pops = 0;

    logic [7:0] in_q[$];
    logic [9:0] m_q[$];
    logic [9:0] log_q[$];

    bit         m_ext, m_brk, m_held, m_hext, m_ovf;
    logic [7:0] m_hcode, m_count;
    int         m_last;
    logic       prev_nd = 1'b1;
    logic [7:0] mon_b;
    logic [31:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_ovf = 0;
        m_hcode = 8'h00; m_count = 8'h00; m_last = 0;
        m_q.delete();
    endfunction

    function automatic void model_push(input logic [9:0] ev);
        if (m_q.size() < DEP) m_q.push_back(ev);
        else m_ovf = 1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [9:0] ev;
        bit same;
        if ((m_ext || m_brk) && (cyc - m_last) > int'(TMO)) begin
            m_ext = 0; m_brk = 0;
        end
        m_last = cyc;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFA || b == 8'hFE)) begin
        end else begin
            ev = {m_brk, m_ext, b};
            same = m_held && (m_hext == m_ext) && (m_hcode == b);
            if (!m_brk) begin
                if (!same) begin
                    model_push(ev);
                    m_count = m_count + 8'd1;
                    m_held = 1; m_hcode = b; m_hext = m_ext;
                end
            end else begin
                model_push(ev);
                if (same) begin
                    m_held = 0; m_hcode = 8'h00; m_hext = 0;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endfunction

    always @(posedge clk) cyc++;

    // Keyboard FIFO and event consumer, both evaluated on the falling edge.
    always @(negedge clk) begin
        if (clrn) begin
            if (!nextdata_n) chk("nd_single_cycle", {31'b0, prev_nd}, 32'd1);
            prev_nd = nextdata_n;
            if (ev_valid && ev_ready) begin
                log_q.push_back(ev_data);
                mon_exp = (m_q.size() != 0) ? {22'b0, m_q.pop_front()} : 'x;
                chk("event", {22'b0, ev_data}, mon_exp);
            end
            if (!nextdata_n) begin
                chk("pop_nonempty", {31'b0, (in_q.size() != 0)}, 32'd1);
                if (in_q.size() != 0) begin
                    mon_b = in_q.pop_front();
                    n_pops++;
                    model_byte(mon_b);
                end
            end
            ready = (in_q.size() != 0);
            data  = ready ? in_q[0] : 8'h00;
        end else begin
            prev_nd = 1'b1;
        end
    end

    task automatic feed(input logic [7:0] b);
        in_q.push_back(b);
    endtask

    task automatic do_reset();
        clrn = 1'b0; ev_ready = 1'b0; ready = 1'b0;
        in_q.delete();
        repeat (2) @(posedge clk);
        model_reset();
        log_q.delete();
        @(posedge clk); #1;
        clrn = 1'b1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
            if (in_q.size() == 0 && nextdata_n && (!ev_ready || m_q.size() == 0)) done = 1;
        end
        chk("drain_done", {31'b0, done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, {24'b0, key_count}, {24'b0, m_count});
        chk({tag, "_held"},  {31'b0, key_held},  {31'b0, m_held});
        chk({tag, "_hcode"}, {24'b0, held_code}, {24'b0, m_hcode});
        chk({tag, "_hext"},  {31'b0, held_ext},  {31'b0, m_hext});
        chk({tag, "_ovf"},   {31'b0, ev_overflow}, {31'b0, m_ovf});
    endtask

    initial begin
        logic [7:0] pool [10];
        int p0;
        bit seen;
        pool = '{8'h1C, 8'h1C, 8'h1D, 8'h75, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h12};

        // reset values
        model_reset();
        repeat (2) @(posedge clk); #1;
        chk("rst_nd",    {31'b0, nextdata_n}, 32'd1);
        chk("rst_valid", {31'b0, ev_valid},   32'd0);
        chk("rst_data",  {22'b0, ev_data},    32'd0);
        chk("rst_count", {24'b0, key_count},  32'd0);
        chk("rst_held",  {31'b0, key_held},   32'd0);
        chk("rst_ovf",   {31'b0, ev_overflow}, 32'd0);
        @(posedge clk); #1; clrn = 1'b1;

        // single make
        ev_ready = 1'b1;
        p0 = n_pops;
        feed(8'h1C);
        wait_drain();
        chk("t1_pops",  n_pops - p0, 32'd1);
        chk("t1_ev",    {22'b0, log_q[0]}, 32'h01C);
        chk("t1_count", {24'b0, key_count}, 32'd1);
        chk("t1_hcode", {24'b0, held_code}, 32'h1C);
        chk("t1_held",  {31'b0, key_held}, 32'd1);

        // typematic repeats then break
        do_reset();
        ev_ready = 1'b1;
        feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
        wait_drain();
        chk("t2_n",     log_q.size(), 32'd2);
        chk("t2_ev0",   {22'b0, log_q[0]}, 32'h01C);
        chk("t2_ev1",   {22'b0, log_q[1]}, 32'h21C);
        chk("t2_count", {24'b0, key_count}, 32'd1);
        chk("t2_held",  {31'b0, key_held}, 32'd0);

        // extended key
        do_reset();
        ev_ready = 1'b1;
        feed(8'hE0); feed(8'h75);
        wait_drain();
        chk("t3_hext_make", {31'b0, held_ext}, 32'd1);
        feed(8'hE0); feed(8'hF0); feed(8'h75);
        wait_drain();
        chk("t3_ev0", {22'b0, log_q[0]}, 32'h175);
        chk("t3_ev1", {22'b0, log_q[1]}, 32'h375);
        chk("t3_hext_brk", {31'b0, held_ext}, 32'd0);

        // queue overflow
        do_reset();
        for (int i = 0; i < 9; i++) feed(8'h15 + 8'(i));
        wait_drain();
        chk("t4_ovf",   {31'b0, ev_overflow}, 32'd1);
        chk("t4_count", {24'b0, key_count}, 32'd9);
        chk("t4_valid", {31'b0, ev_valid}, 32'd1);
        chk("t4_hcode", {24'b0, held_code}, 32'h1D);
        ev_ready = 1'b1;
        wait_drain();
        chk("t4_n",     log_q.size(), 32'd8);
        chk("t4_first", {22'b0, log_q[0]}, 32'h015);
        chk("t4_last",  {22'b0, log_q[7]}, 32'h01C);

        // prefix timeout
        do_reset();
        ev_ready = 1'b1;
        feed(8'hF0);
        wait_drain();
        repeat (20) @(posedge clk);
        feed(8'h1C);
        wait_drain();
        chk("t5_n",    log_q.size(), 32'd1);
        chk("t5_ev",   {22'b0, log_q[0]}, 32'h01C);
        chk("t5_held", {31'b0, key_held}, 32'd1);

        // reset during POP
        do_reset();
        ev_ready = 1'b1;
        feed(8'h1C); feed(8'h1D);
        wait_drain();
        p0 = n_pops;
        feed(8'h24);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (!nextdata_n) seen = 1;
        end
        chk("t6_pop_seen", {31'b0, seen}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("t6_nd",    {31'b0, nextdata_n}, 32'd1);
        chk("t6_valid", {31'b0, ev_valid}, 32'd0);
        chk("t6_data",  {22'b0, ev_data}, 32'd0);
        chk("t6_count", {24'b0, key_count}, 32'd0);
        chk("t6_held",  {31'b0, key_held}, 32'd0);
        chk("t6_hcode", {24'b0, held_code}, 32'd0);
        repeat (2) @(posedge clk);
        model_reset();
        log_q.delete();
        @(posedge clk); #1;
        clrn = 1'b1;
        wait_drain();
        chk("t6_pops",  n_pops - p0, 32'd1);
        chk("t6_ev",    {22'b0, log_q[0]}, 32'h024);
        chk("t6_count", {24'b0, key_count}, 32'd1);

        // counter wrap
        do_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < 256; i++) feed(i[0] ? 8'h1D : 8'h1C);
        wait_drain();
        chk("wrap_count", {24'b0, key_count}, 32'd0);
        chk("wrap_n",     log_q.size(), 32'd256);

        // randomized stream against the reference model
        do_reset();
        for (int i = 0; i < 300; i++) feed(pool[$urandom_range(0, 9)]);
        for (int i = 0; i < 2000 && in_q.size() != 0; i++) begin
            @(posedge clk); #1;
            ev_ready = ($urandom_range(0, 3) != 0);
        end
        ev_ready = 1'b1;
        wait_drain();
        chk_state("rand");
        chk("rand_empty", {31'b0, ev_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
